wb_data_ram: RTL
================

WB_DATA_RAM -- requirements
Module: wb_data_ram

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 1024, memory depth in 32-bit words (power of two, >=2).
REQ-002 SHALL provide parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0 (DEPTH_WORDS*4 aligned).
REQ-003 SHALL provide parameter WAIT_STATES, default 1, extra cycles inserted before ack (0..15).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port wishbone_bus, wishbone_if.slave, bundle: cycle/strobe/write_enable in 1, select in 4, address in 32, data_in in 32, data_out out 32, ack out 1.

Function
REQ-007 SHALL implement states IDLE, WAIT, ACK.
REQ-008 IDLE: a request is cycle&strobe high; on a request, latch address, write_enable, select and data_in. Go to ACK if WAIT_STATES==0, else go to WAIT with counter=WAIT_STATES-1.
REQ-009 WAIT: if counter!=0, decrement. If counter==0, perform the access and go to ACK.
REQ-010 WAIT: if cycle or strobe is low, abort to IDLE; no write, no ack, data_out unchanged (abort takes priority over access).
REQ-011 ACK: ack=1 for exactly one cycle, then unconditional return to IDLE; bus inputs not sampled in ACK.
REQ-012 Latency: request first seen in cycle 0 -> ack high in cycle WAIT_STATES+1; back-to-back request earliest accepted cycle WAIT_STATES+2.
REQ-013 Word index = address[log2(DEPTH_WORDS)+1:2] of (address-BASE_ADDR); address[1:0] ignored.
REQ-014 Write: byte lane i (bits 8i+7:8i) updated from latched data_in only if select[i]=1; select=4'b0000 acks with no change.
REQ-015 Read: returns full 32-bit word regardless of select; registered into data_out, valid in ack cycle.
REQ-016 data_out SHALL hold last read value outside ack cycles; writes do not alter data_out.
REQ-017 ack SHALL never be high while in IDLE or WAIT; at most one ack per accepted request.

Reset
REQ-018 On reset: state=IDLE, ack=0, data_out=32'd0, counter=0, latched request cleared.
REQ-019 Reset mid-operation (WAIT or ACK) SHALL discard the pending access; no memory update, no ack in following cycle.
REQ-020 Memory array contents SHALL NOT be reset.

Configuration
REQ-021 Macro WB_RAM_ADDR_CHECK_EN SHALL gate out-of-range detection.
REQ-022 With WB_RAM_ADDR_CHECK_EN: address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4) still acked with normal latency; write dropped; read returns 32'hDEAD_BEEF.
REQ-023 Without WB_RAM_ADDR_CHECK_EN: no check; the index wraps modulo DEPTH_WORDS.

Structure
REQ-024 Package wb_pkg SHALL hold the state typedef (IDLE/WAIT/ACK) and constant WB_BAD_ADDR_DATA=32'hDEAD_BEEF.
REQ-025 Storage SHALL be sub-module ram_1rw_be: single-port, 4 byte enables, registered read, one access per cycle.
REQ-026 FSM, counter and request latch SHALL reside in wb_data_ram.

Verification
REQ-027 Write 32'h1234_5678 to BASE_ADDR+8, select 4'b1111, WAIT_STATES=1 -> ack in cycle 2 only. Read BASE_ADDR+8 -> data_out=32'h1234_5678 in ack cycle.
REQ-028 Preload 32'hAABB_CCDD. Write 32'h1122_3344 with select 4'b0101 -> read returns 32'hAA22_CC44.
REQ-029 WAIT_STATES=3: strobe dropped in cycle 2 of a write -> no ack, later read shows old word. Next full request acks in cycle 4.
REQ-030 WAIT_STATES=0, master holds strobe through ack -> ack high for exactly one cycle in cycle 1, no second ack.
REQ-031 With WB_RAM_ADDR_CHECK_EN, read BASE_ADDR+DEPTH_WORDS*4 -> ack with 32'hDEAD_BEEF. Without it, the same read returns word 0.
REQ-032 Reset asserted during WAIT of a write -> ack=0 and data_out=0 next cycle, target word unchanged.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the Wishbone data RAM
package wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } wb_state_e;

   // Returned for reads that fall outside the RAM window when address checking is built in
   localparam logic [31:0] WB_BAD_ADDR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wishbone_if.sv
// rtl/wishbone_if.sv - single-beat Wishbone bus bundle
interface wishbone_if;

   logic        cycle;
   logic        strobe;
   logic        write_enable;
   logic [3:0]  select;
   logic [31:0] address;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        ack;

   modport master (
      output cycle, strobe, write_enable, select, address, data_in,
      input  data_out, ack
   );

   modport slave (
      input  cycle, strobe, write_enable, select, address, data_in,
      output data_out, ack
   );

endinterface

// File: rtl/ram_1rw_be.sv
// rtl/ram_1rw_be.sv - single-port RAM, byte enables, registered read
module ram_1rw_be #(
   parameter  int DEPTH_WORDS = 1024,
   localparam int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          en_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // Byte-lane writes; the array itself is never reset
   always_ff @(posedge clk_i) begin
      if (en_i && we_i) begin
         for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
               mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
   end

   // Read register loads only on reads, so it holds the last read across writes
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rdata_q <= '0;
      end else if (en_i && !we_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_data_ram.sv
// rtl/wb_data_ram.sv - Wishbone slave RAM with wait states; WB_RAM_ADDR_CHECK_EN adds range checking
module wb_data_ram
   import wb_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 1
) (
   input logic        clk,
   input logic        reset,
   wishbone_if.slave  wishbone_bus
);

   localparam int          AW    = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  WS_M1 = 4'(WAIT_STATES - 1);

   wb_state_e   state_q;
   logic [3:0]  cnt_q;
   logic        we_q;
   logic [3:0]  sel_q;
   logic [31:0] adr_q;
   logic [31:0] dat_q;
   logic        ack_q;

   logic        req;
   logic        acc_en;
   logic        acc_we;
   logic [3:0]  acc_sel;
   logic [31:0] acc_adr;
   logic [31:0] acc_dat;
   logic [31:0] offset;
   logic        in_range;
   logic        ram_en;
   logic [31:0] ram_rdata;
   logic        unused_bits;

   assign req = wishbone_bus.cycle && wishbone_bus.strobe;

   // With zero wait states the access happens on the accepting edge, straight from the bus
   always_comb begin
      acc_en  = 1'b0;
      acc_we  = we_q;
      acc_sel = sel_q;
      acc_adr = adr_q;
      acc_dat = dat_q;
      if (state_q == IDLE) begin
         acc_we  = wishbone_bus.write_enable;
         acc_sel = wishbone_bus.select;
         acc_adr = wishbone_bus.address;
         acc_dat = wishbone_bus.data_in;
         acc_en  = req && (WAIT_STATES == 0);
      end else if (state_q == WAIT) begin
         acc_en  = req && (cnt_q == 4'd0);
      end
      if (reset) begin
         acc_en = 1'b0;
      end
   end

   assign offset = acc_adr - BASE_ADDR;

`ifdef WB_RAM_ADDR_CHECK_EN
   assign in_range    = (offset < SPAN);
   assign unused_bits = ^offset[1:0];
`else
   assign in_range    = 1'b1;
   assign unused_bits = ^{offset[31:AW+2], offset[1:0]};
`endif

   assign ram_en = acc_en && in_range;

   ram_1rw_be #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_ram (
      .clk_i   (clk),
      .reset_i (reset),
      .en_i    (ram_en),
      .we_i    (acc_we),
      .be_i    (acc_sel),
      .addr_i  (offset[AW+1:2]),
      .wdata_i (acc_dat),
      .rdata_o (ram_rdata)
   );

`ifdef WB_RAM_ADDR_CHECK_EN
   logic bad_rd_q;

   // Remembers whether the most recent read missed the window so data_out keeps showing the marker
   always_ff @(posedge clk) begin
      if (reset) begin
         bad_rd_q <= 1'b0;
      end else if (acc_en && !acc_we) begin
         bad_rd_q <= !in_range;
      end
   end

   assign wishbone_bus.data_out = bad_rd_q ? WB_BAD_ADDR_DATA : ram_rdata;
`else
   assign wishbone_bus.data_out = ram_rdata;
`endif

   // Request FSM: latch on accept, count wait states, abort if the master lets go, single-cycle ack
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         ack_q   <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= 4'd0;
         adr_q   <= 32'd0;
         dat_q   <= 32'd0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req) begin
                  we_q  <= wishbone_bus.write_enable;
                  sel_q <= wishbone_bus.select;
                  adr_q <= wishbone_bus.address;
                  dat_q <= wishbone_bus.data_in;
                  if (WAIT_STATES == 0) begin
                     state_q <= ACK;
                     ack_q   <= 1'b1;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= WS_M1;
                  end
               end
            end
            WAIT: begin
               if (!req) begin
                  state_q <= IDLE;
               end else if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  state_q <= ACK;
                  ack_q   <= 1'b1;
               end
            end
            ACK: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign wishbone_bus.ack = ack_q;

endmodule
